// File: rtl/tx_intf_s_axis_mq.sv
// Multi-queue AXI-Stream ingress buffer for the tx_intf datapath.
// Each DMA burst from the PS is steered into one of NUM_QUEUE first-word-
// fall-through FIFOs; the queue index is latched when the burst starts.
// The accelerator drains whichever queue tx_queue_idx selects.
//
// Handshake: a beat transfers on a rising S_AXIS_ACLK edge where both
// S_AXIS_TVALID and S_AXIS_TREADY are high. TREADY never depends on TVALID
// inside a cycle. A queue that is full holds TREADY low, so no beat is dropped.
// Flushing the target queue still accepts the beat and then discards it.
// On the read side, DATA_TO_ACC is valid whenever EMPTYN_TO_ACC is high, and
// ACC_ASK_DATA pops that word on the next edge.
module tx_intf_s_axis_mq #(
    parameter int NUM_QUEUE              = 4,
    parameter int QUEUE_IDX_WIDTH        = 2,
    parameter int C_S_AXIS_TDATA_WIDTH   = 64,
    parameter int FIFO_DEPTH_LOG2        = 12,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic                                       S_AXIS_ACLK,
    input  logic                                       S_AXIS_ARESET,
    input  logic [QUEUE_IDX_WIDTH-1:0]                 tx_queue_idx_indication_from_ps,
    input  logic [QUEUE_IDX_WIDTH-1:0]                 tx_queue_idx,
    input  logic                                       endless_mode,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]          S_AXIS_NUM_DMA_SYMBOL,
    input  logic [NUM_QUEUE-1:0]                       queue_flush,
    input  logic                                       S_AXIS_TVALID,
    output logic                                       S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]            S_AXIS_TDATA,
    input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0]        S_AXIS_TSTRB,
    input  logic                                       S_AXIS_TLAST,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]            DATA_TO_ACC,
    output logic                                       EMPTYN_TO_ACC,
    input  logic                                       ACC_ASK_DATA,
    output logic [NUM_QUEUE*(FIFO_DEPTH_LOG2+1)-1:0]   data_count,
    output logic [NUM_QUEUE*8-1:0]                     burst_count,
    output logic                                       burst_done,
    output logic                                       s_axis_recv_data_from_high
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int BW    = MAX_BIT_NUM_DMA_SYMBOL + 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic [QUEUE_IDX_WIDTH-1:0]   wq, wq_nxt;
    logic [BW-1:0]                beat_cnt, beat_cnt_nxt;
    logic [BW-1:0]                num_ext;
    logic                         tready;
    logic                         done_pulse;
    logic                         accept;
    logic                         wq_full;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [NUM_QUEUE][DEPTH];
    logic [PW-1:0]                   wr_ptr [NUM_QUEUE];
    logic [PW-1:0]                   rd_ptr [NUM_QUEUE];
    logic [CW-1:0]                   cnt    [NUM_QUEUE];
    logic [7:0]                      bcnt   [NUM_QUEUE];
    logic [NUM_QUEUE-1:0]            full;
    logic [NUM_QUEUE-1:0]            push;
    logic [NUM_QUEUE-1:0]            pop;

    // Byte strobes carry no information for this datapath.
    logic unused_tstrb;
    assign unused_tstrb = ^S_AXIS_TSTRB;

    assign num_ext = {1'b0, S_AXIS_NUM_DMA_SYMBOL};

    // Full flag of the queue latched for the current burst.
    always_comb begin
        wq_full = 1'b0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (wq == QUEUE_IDX_WIDTH'(q)) begin
                wq_full = full[q];
            end
        end
    end

    // Burst FSM: next state, beat counting and handshake outputs.
    always_comb begin
        state_nxt    = state;
        wq_nxt       = wq;
        beat_cnt_nxt = beat_cnt;
        tready       = 1'b0;
        done_pulse   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (S_AXIS_TVALID) begin
                    wq_nxt    = tx_queue_idx_indication_from_ps;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                tready = !wq_full && ((beat_cnt <= num_ext) || endless_mode);
                if (S_AXIS_TVALID && tready) begin
                    if (!endless_mode || beat_cnt != {BW{1'b1}}) begin
                        beat_cnt_nxt = beat_cnt + BW'(1);
                    end
                    if (S_AXIS_TLAST || (!endless_mode && beat_cnt == num_ext)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_pulse   = 1'b1;
                beat_cnt_nxt = '0;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst FSM state register.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state    <= ST_IDLE;
            wq       <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wq       <= wq_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign accept                     = S_AXIS_TVALID && tready;
    assign S_AXIS_TREADY              = tready;
    assign burst_done                 = done_pulse;
    assign s_axis_recv_data_from_high = (state != ST_IDLE);

    // Per-queue push/pop strobes; a flush overrides both.
    always_comb begin
        push = '0;
        pop  = '0;
        full = '0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            full[q] = (cnt[q] == CW'(DEPTH));
            push[q] = accept && (wq == QUEUE_IDX_WIDTH'(q)) && !queue_flush[q];
            pop[q]  = ACC_ASK_DATA && (tx_queue_idx == QUEUE_IDX_WIDTH'(q)) &&
                      (cnt[q] != '0) && !queue_flush[q];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge S_AXIS_ACLK) begin
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (push[q]) begin
                mem[q][wr_ptr[q]] <= S_AXIS_TDATA;
            end
        end
    end

    // FIFO pointers, word counts and completed-burst counters.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
                cnt[q]    <= '0;
                bcnt[q]   <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                if (queue_flush[q]) begin
                    wr_ptr[q] <= '0;
                    rd_ptr[q] <= '0;
                    cnt[q]    <= '0;
                    bcnt[q]   <= '0;
                end else begin
                    if (push[q]) begin
                        wr_ptr[q] <= wr_ptr[q] + PW'(1);
                    end
                    if (pop[q]) begin
                        rd_ptr[q] <= rd_ptr[q] + PW'(1);
                    end
                    if (push[q] && !pop[q]) begin
                        cnt[q] <= cnt[q] + CW'(1);
                    end else if (pop[q] && !push[q]) begin
                        cnt[q] <= cnt[q] - CW'(1);
                    end
                    if (done_pulse && (wq == QUEUE_IDX_WIDTH'(q))) begin
                        bcnt[q] <= bcnt[q] + 8'd1;
                    end
                end
            end
        end
    end

    // First-word-fall-through read mux over the selected queue.
    always_comb begin
        DATA_TO_ACC   = '0;
        EMPTYN_TO_ACC = 1'b0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            if (tx_queue_idx == QUEUE_IDX_WIDTH'(q)) begin
                DATA_TO_ACC   = mem[q][rd_ptr[q]];
                EMPTYN_TO_ACC = (cnt[q] != '0);
            end
        end
    end

    // Packed status vectors.
    always_comb begin
        data_count  = '0;
        burst_count = '0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            data_count[q*CW +: CW] = cnt[q];
            burst_count[q*8 +: 8]  = bcnt[q];
        end
    end

endmodule

// File: tb/tb_tx_intf_s_axis_mq.sv
// Bench for tx_intf_s_axis_mq: directed burst scenarios plus randomized bursts,
// compared every cycle against a queue-based behavioural model.
module tb_tx_intf_s_axis_mq;

    localparam int NQ    = 4;
    localparam int QIW   = 2;
    localparam int W     = 64;
    localparam int DL2   = 5;
    localparam int MB    = 14;
    localparam int DEPTH = 1 << DL2;
    localparam int CW    = DL2 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [QIW-1:0]     ind = '0;
    logic [QIW-1:0]     tx_queue_idx = '0;
    logic               endless_mode = 1'b0;
    logic [MB-1:0]      num_sym = '0;
    logic [NQ-1:0]      queue_flush = '0;
    logic               S_AXIS_TVALID = 1'b0;
    logic               S_AXIS_TREADY;
    logic [W-1:0]       S_AXIS_TDATA = '0;
    logic [W/8-1:0]     S_AXIS_TSTRB = '1;
    logic               S_AXIS_TLAST = 1'b0;
    logic [W-1:0]       DATA_TO_ACC;
    logic               EMPTYN_TO_ACC;
    logic               ACC_ASK_DATA = 1'b0;
    logic [NQ*CW-1:0]   data_count;
    logic [NQ*8-1:0]    burst_count;
    logic               burst_done;
    logic               recv_high;

    tx_intf_s_axis_mq #(
        .NUM_QUEUE(NQ), .QUEUE_IDX_WIDTH(QIW), .C_S_AXIS_TDATA_WIDTH(W),
        .FIFO_DEPTH_LOG2(DL2), .MAX_BIT_NUM_DMA_SYMBOL(MB)
    ) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst),
        .tx_queue_idx_indication_from_ps(ind), .tx_queue_idx(tx_queue_idx),
        .endless_mode(endless_mode), .S_AXIS_NUM_DMA_SYMBOL(num_sym),
        .queue_flush(queue_flush), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
        .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TLAST(S_AXIS_TLAST),
        .DATA_TO_ACC(DATA_TO_ACC), .EMPTYN_TO_ACC(EMPTYN_TO_ACC),
        .ACC_ASK_DATA(ACC_ASK_DATA), .data_count(data_count),
        .burst_count(burst_count), .burst_done(burst_done),
        .s_axis_recv_data_from_high(recv_high)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] dc(int q);
        return 64'(data_count[q*CW +: CW]);
    endfunction

    function automatic logic [63:0] bc(int q);
        return 64'(burst_count[q*8 +: 8]);
    endfunction

    // ---------------- behavioural model + scoreboard ----------------
    // Phase: 0 waiting for a burst, 1 accepting beats, 2 burst completion cycle.
    logic [W-1:0] mq [NQ][$];
    int           m_bc [NQ];
    int           m_phase = 0;
    int           m_wq = 0;
    int           m_beats = 0;
    int           done_pulses = 0;
    int           sel;
    logic         e_rdy, e_emp, acc, popq;
    logic [NQ*CW-1:0] e_dc;
    logic [NQ*8-1:0]  e_bc;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                mq[i].delete();
                m_bc[i] = 0;
            end
            m_phase = 0;
            m_wq    = 0;
            m_beats = 0;
        end
        sel   = int'(tx_queue_idx);
        e_rdy = (m_phase == 1) && (mq[m_wq].size() < DEPTH) &&
                (endless_mode || m_beats <= int'(num_sym));
        e_emp = (mq[sel].size() != 0);
        for (int i = 0; i < NQ; i++) begin
            e_dc[i*CW +: CW] = CW'(mq[i].size());
            e_bc[i*8 +: 8]   = 8'(m_bc[i] % 256);
        end
        chk("tready", 64'(S_AXIS_TREADY), 64'(e_rdy));
        chk("burst_done", 64'(burst_done), 64'(m_phase == 2));
        chk("recv_high", 64'(recv_high), 64'(m_phase != 0));
        chk("emptyn", 64'(EMPTYN_TO_ACC), 64'(e_emp));
        if (e_emp) chk("data_to_acc", DATA_TO_ACC, mq[sel][0]);
        chk("data_count", 64'(data_count), 64'(e_dc));
        chk("burst_count", 64'(burst_count), 64'(e_bc));
        if (burst_done) done_pulses++;
        if (!rst) begin
            acc  = S_AXIS_TVALID && e_rdy;
            popq = ACC_ASK_DATA && e_emp;
            if (popq && !queue_flush[sel]) void'(mq[sel].pop_front());
            if (acc && !queue_flush[m_wq]) mq[m_wq].push_back(S_AXIS_TDATA);
            case (m_phase)
                0: if (S_AXIS_TVALID) begin m_wq = int'(ind); m_phase = 1; end
                1: if (acc) begin
                       if (S_AXIS_TLAST || (!endless_mode && m_beats == int'(num_sym))) m_phase = 2;
                       m_beats++;
                   end
                default: begin
                       m_bc[m_wq] = (m_bc[m_wq] + 1) % 256;
                       m_phase = 0;
                       m_beats = 0;
                   end
            endcase
            for (int i = 0; i < NQ; i++) begin
                if (queue_flush[i]) begin
                    mq[i].delete();
                    m_bc[i] = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [W-1:0] sent_q [$];
    bit           bg_stop;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers up to max_beats beats (TLAST on beat last_at, 0 = never) and
    // returns once the burst completion pulse is seen.
    task automatic send_burst(input int q, input int num, input bit endl,
                              input int last_at, input int max_beats, input int gap_pct);
        int k, cyc;
        bit fin, hs;
        k = 1; cyc = 0; fin = 0;
        sent_q.delete();
        ind = QIW'(q);
        num_sym = MB'(num);
        endless_mode = endl;
        while (!fin) begin
            if (!S_AXIS_TVALID && k <= max_beats && int'($urandom_range(99)) >= gap_pct) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = {$urandom, $urandom};
                S_AXIS_TLAST  = (k == last_at);
            end
            @(negedge clk);
            hs = S_AXIS_TVALID && S_AXIS_TREADY;
            if (hs) begin
                sent_q.push_back(S_AXIS_TDATA);
                k++;
            end
            if (burst_done) fin = 1;
            @(posedge clk);
            #1;
            if (hs || fin) begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TLAST  = 1'b0;
            end
            cyc++;
            if (!fin && cyc > 600) begin
                checks++;
                errors++;
                $display("FAIL burst_timeout: got no burst_done after %0d cycles, required one", cyc);
                S_AXIS_TVALID = 1'b0;
                fin = 1;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, cyc, pend;
        bit fin, hs;
        int q, num, la, mb;
        bit endl;

        repeat (3) step();
        chk("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        chk("rst_emptyn", 64'(EMPTYN_TO_ACC), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", 64'(burst_done), 64'd0);
        chk("rst_data_count", 64'(data_count), 64'd0);
        chk("rst_burst_count", 64'(burst_count), 64'd0);
        chk("rst_recv_high", 64'(recv_high), 64'd0);
        step();

        // 1: NUM=3 without TLAST into queue 2, TVALID held throughout
        send_burst(2, 3, 0, 0, 100, 0);
        repeat (2) step();
        chk("t1_beats", 64'(sent_q.size()), 64'd4);
        chk("t1_dc2", dc(2), 64'd4);
        chk("t1_bc2", bc(2), 64'd1);
        chk("t1_others", dc(0) + dc(1) + dc(3) + bc(0) + bc(1) + bc(3), 64'd0);
        chk("t1_pulses", 64'(done_pulses), 64'd1);

        // 2: NUM=100, TLAST on beat 5 into queue 1
        send_burst(1, 100, 0, 5, 5, 20);
        repeat (2) step();
        chk("t2_dc1", dc(1), 64'd5);
        chk("t2_bc1", bc(1), 64'd1);
        chk("t2_pulses", 64'(done_pulses), 64'd2);

        // 3: endless, 20 beats into queue 0, then drain back-to-back
        send_burst(0, 0, 1, 20, 20, 0);
        endless_mode = 1'b0;
        step();
        chk("t3_dc0", dc(0), 64'd20);
        tx_queue_idx = 2'd0;
        ACC_ASK_DATA = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_rd_emptyn", 64'(EMPTYN_TO_ACC), 64'd1);
            chk("t3_rd_data", DATA_TO_ACC, sent_q[i]);
            step();
        end
        @(negedge clk);
        chk("t3_rd_empty_after", 64'(EMPTYN_TO_ACC), 64'd0);
        step();
        ACC_ASK_DATA = 1'b0;

        // 4: fill queue 3 to capacity, one pop admits exactly one more beat
        fork
            send_burst(3, DEPTH + 3, 0, 0, DEPTH + 4, 0);
            begin
                repeat (DEPTH + 10) step();
                @(negedge clk); #2;
                chk("t4_full_dc3", dc(3), 64'(DEPTH));
                chk("t4_full_tready", 64'(S_AXIS_TREADY), 64'd0);
                step();
                tx_queue_idx = 2'd3;
                ACC_ASK_DATA = 1'b1;
                step();
                ACC_ASK_DATA = 1'b0;
                repeat (5) step();
                @(negedge clk); #2;
                chk("t4_after_pop_dc3", dc(3), 64'(DEPTH));
                chk("t4_after_pop_beats", 64'(sent_q.size()), 64'(DEPTH + 1));
                step();
                ACC_ASK_DATA = 1'b1;
                repeat (DEPTH + 10) step();
                ACC_ASK_DATA = 1'b0;
            end
        join
        step();
        chk("t4_beats", 64'(sent_q.size()), 64'(DEPTH + 4));
        chk("t4_bc3", bc(3), 64'd1);

        // 5: mid-burst index switch and flush of queue 1 during beat 3
        num_sym = MB'(9);
        endless_mode = 1'b0;
        ind = 2'd1;
        S_AXIS_TDATA = {$urandom, $urandom};
        S_AXIS_TVALID = 1'b1;
        k = 0; cyc = 0; fin = 0; pend = 0;
        while (!fin) begin
            @(negedge clk);
            if (pend == 1) begin
                chk("t5_flushed_dc1", dc(1), 64'd0);
                pend = 2;
            end
            hs = S_AXIS_TVALID && S_AXIS_TREADY;
            if (hs) k++;
            if (hs && k == 3) pend = 1;
            if (burst_done) fin = 1;
            step();
            queue_flush = '0;
            if (hs) S_AXIS_TDATA = {$urandom, $urandom};
            if (k >= 1) ind = 2'd0;
            if (hs && k == 2) queue_flush = 4'b0010;
            if (fin) S_AXIS_TVALID = 1'b0;
            cyc++;
            if (!fin && cyc > 100) begin
                checks++;
                errors++;
                $display("FAIL t5_timeout: got no burst_done after %0d cycles, required one", cyc);
                S_AXIS_TVALID = 1'b0;
                fin = 1;
            end
        end
        step();
        chk("t5_beats", 64'(k), 64'd10);
        chk("t5_dc1", dc(1), 64'd7);
        chk("t5_bc1", bc(1), 64'd1);
        chk("t5_dc0", dc(0), 64'd0);
        chk("t5_bc0", bc(0), 64'd1);

        // random bursts with background pops, queue switching and flushes
        for (int n = 0; n < 10; n++) begin
            q    = int'($urandom_range(NQ - 1));
            num  = int'($urandom_range(12));
            endl = 1'($urandom_range(1));
            if (endl) la = int'($urandom_range(15, 1));
            else la = ($urandom_range(1) == 1) ? int'($urandom_range(num + 3, 1)) : 0;
            mb = endl ? la : ((la != 0 && la <= num + 1) ? la : num + 1);
            bg_stop = 0;
            fork
                begin
                    send_burst(q, num, endl, la, mb, 30);
                    bg_stop = 1;
                end
                begin
                    while (!bg_stop) begin
                        step();
                        ACC_ASK_DATA = 1'($urandom_range(1));
                        tx_queue_idx = QIW'($urandom_range(NQ - 1));
                        queue_flush  = ($urandom_range(15) == 0) ? NQ'(1 << $urandom_range(NQ - 1)) : '0;
                    end
                end
            join
            ACC_ASK_DATA = 1'b0;
            queue_flush  = '0;
            step();
        end

        // 6: asynchronous reset in the middle of a burst
        endless_mode = 1'b0;
        tx_queue_idx = 2'd2;
        ind = 2'd2;
        num_sym = MB'(7);
        S_AXIS_TDATA = {$urandom, $urandom};
        S_AXIS_TVALID = 1'b1;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        S_AXIS_TVALID = 1'b0;
        chk("t6_tready", 64'(S_AXIS_TREADY), 64'd0);
        chk("t6_emptyn", 64'(EMPTYN_TO_ACC), 64'd0);
        chk("t6_data_count", 64'(data_count), 64'd0);
        chk("t6_burst_count", 64'(burst_count), 64'd0);
        step();
        rst = 1'b0;
        step();
        send_burst(2, 2, 0, 0, 3, 0);
        step();
        chk("t6_after_dc2", dc(2), 64'd3);
        chk("t6_after_bc2", bc(2), 64'd1);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
